// File: rtl/ram_stream_reader_pkg.sv
// Shared types and sizing constants for the RAM-to-stream reader.
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/ram_rd_fifo.sv
// Two-entry FIFO holding RAM words between the read port and the output stream.
module ram_rd_fifo
    import ram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [FIFO_CNT_W-1:0] count,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_CNT_W-1:0] count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads num_words consecutive RAM words from base_addr and streams them out with valid/ready.
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_RUN   | issuing reads, streaming returned words
//   ST_DRAIN | all reads issued, emptying the FIFO
//   ST_DONE  | one-cycle completion pulse
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
    output logic                  busy,
    output logic                  done,
    output logic                  m_read_req,
    output logic [ADDR_WIDTH-1:0] m_read_addr,
    input  logic [DATA_WIDTH-1:0] m_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam logic [FIFO_CNT_W:0] OCC_LIMIT = (FIFO_CNT_W + 1)'(FIFO_DEPTH);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic [ADDR_WIDTH:0]   reads_left_q, reads_left_d;
    logic [ADDR_WIDTH:0]   words_left_q, words_left_d;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  rd_pending;
    logic [FIFO_CNT_W:0]   occupancy;
    logic                  read_ok;

    generate
        if (READ_LATENCY == 0) begin : g_comb_read
            assign rd_pending = 1'b0;
            assign fifo_push  = m_read_req;
        end else begin : g_reg_read
            logic pending_q, pending_d;

            always_comb pending_d = m_read_req;

            // Clearing on reset drops any word still returning from an aborted transfer.
            always_ff @(posedge clk) begin
                if (!reset_n) pending_q <= 1'b0;
                else          pending_q <= pending_d;
            end

            assign rd_pending = pending_q;
            assign fifo_push  = pending_q;
        end
    endgenerate

    ram_rd_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (m_read_data),
        .pop       (fifo_pop),
        .pop_data  (out_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;
    assign out_last  = out_valid && (words_left_q == (ADDR_WIDTH + 1)'(1));

    // Words stored plus words still on their way must never exceed the FIFO depth.
    assign occupancy = {1'b0, fifo_count} + {{FIFO_CNT_W{1'b0}}, rd_pending};
    assign read_ok   = (!fifo_full && (occupancy < OCC_LIMIT))
                    || (fifo_pop && (occupancy == OCC_LIMIT));

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        last_addr_d  = last_addr_q;
        reads_left_d = reads_left_q;
        words_left_d = words_left_q;
        m_read_req   = 1'b0;

        if (fifo_pop) begin
            words_left_d = words_left_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d       = base_addr;
                    reads_left_d = num_words;
                    words_left_d = num_words;
                    state_d      = (num_words == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (read_ok) begin
                    m_read_req   = 1'b1;
                    last_addr_d  = addr_q;
                    addr_d       = addr_q + 1'b1;
                    reads_left_d = reads_left_q - 1'b1;
                    if (reads_left_q == (ADDR_WIDTH + 1)'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_pop && (words_left_q == (ADDR_WIDTH + 1)'(1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            last_addr_q  <= '0;
            reads_left_q <= '0;
            words_left_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            last_addr_q  <= last_addr_d;
            reads_left_q <= reads_left_d;
            words_left_q <= words_left_d;
        end
    end

    assign m_read_addr = m_read_req ? addr_q : last_addr_q;
    assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench: two readers (combinational and registered RAM) run the same transfers side by side.
module tb_ram_stream_reader;

    localparam int DW     = 8;
    localparam int AW     = 10;
    localparam int NWORDS = 1 << AW;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          start;
    logic          out_ready;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;

    logic          busy        [2];
    logic          done        [2];
    logic          m_read_req  [2];
    logic [AW-1:0] m_read_addr [2];
    logic [DW-1:0] m_read_data [2];
    logic          out_valid   [2];
    logic [DW-1:0] out_data    [2];
    logic          out_last    [2];

    logic [DW-1:0] ram [NWORDS];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    word_t exp_words [2][$];
    int    exp_addr  [2][$];

    bit            active      [2];
    bit            done_seen   [2];
    int            start_win   [2];
    int            xfer_num    [2];
    int            words_seen  [2];
    int            reads_seen  [2];
    int            first_hs    [2];
    int            last_hs     [2];
    bit            stall_prev  [2];
    logic [DW-1:0] stall_data  [2];
    logic          stall_last  [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s lat%0d actual=0x%0h required=0x%0h t=%0t", name, g, act, exp, $time);
        end
    endtask

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            ram_stream_reader #(
                .DATA_WIDTH   (DW),
                .ADDR_WIDTH   (AW),
                .READ_LATENCY (g)
            ) u_dut (
                .clk         (clk),
                .reset_n     (reset_n),
                .start       (start),
                .base_addr   (base_addr),
                .num_words   (num_words),
                .busy        (busy[g]),
                .done        (done[g]),
                .m_read_req  (m_read_req[g]),
                .m_read_addr (m_read_addr[g]),
                .m_read_data (m_read_data[g]),
                .out_valid   (out_valid[g]),
                .out_ready   (out_ready),
                .out_data    (out_data[g]),
                .out_last    (out_last[g])
            );

            if (g == 0) begin : g_ram_comb
                assign m_read_data[g] = ram[m_read_addr[g]];
            end else begin : g_ram_reg
                logic [DW-1:0] rdata_q = '0;
                always @(posedge clk) if (m_read_req[g]) rdata_q <= ram[m_read_addr[g]];
                assign m_read_data[g] = rdata_q;
            end

            // Monitor: compares whatever the DUT presents against the queued expectations.
            always @(negedge clk) begin
                word_t w;
                if (!reset_n) begin
                    stall_prev[g] = 1'b0;
                end else begin
                    if (m_read_req[g]) begin
                        reads_seen[g]++;
                        if (exp_addr[g].size() == 0) check("unexpected_read", g, 1, 0);
                        else check("read_addr", g, 32'(m_read_addr[g]), exp_addr[g].pop_front());
                    end
                    if (stall_prev[g]) begin
                        check("stall_valid", g, 32'(out_valid[g]), 1);
                        check("stall_data", g, 32'(out_data[g]), 32'(stall_data[g]));
                        check("stall_last", g, 32'(out_last[g]), 32'(stall_last[g]));
                    end
                    if (out_valid[g] && out_ready) begin
                        if (exp_words[g].size() == 0) begin
                            check("extra_word", g, 1, 0);
                        end else begin
                            w = exp_words[g].pop_front();
                            check("out_data", g, 32'(out_data[g]), 32'(w.data));
                            check("out_last", g, 32'(out_last[g]), 32'(w.last));
                        end
                        words_seen[g]++;
                        if (words_seen[g] == 1) first_hs[g] = cyc;
                        last_hs[g] = cyc;
                    end
                    stall_prev[g] = out_valid[g] && !out_ready;
                    stall_data[g] = out_data[g];
                    stall_last[g] = out_last[g];
                    if (active[g] && cyc == start_win[g] + 1)
                        check("busy_after_start", g, 32'(busy[g]), 32'(xfer_num[g] != 0));
                    if (done[g]) begin
                        if (!active[g]) begin
                            check("spurious_done", g, 1, 0);
                        end else begin
                            check("done_cycle", g, cyc,
                                  (xfer_num[g] == 0) ? start_win[g] + 1 : last_hs[g] + 1);
                            check("busy_at_done", g, 32'(busy[g]), 0);
                            check("word_count", g, words_seen[g], xfer_num[g]);
                            check("read_count", g, reads_seen[g], xfer_num[g]);
                            active[g]    = 1'b0;
                            done_seen[g] = 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    function automatic logic ready_val(input int mode, input int step);
        case (mode)
            0:       return 1'b1;
            1:       return (step % 4 == 0) || (step % 4 == 3);
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        for (int g = 0; g < 2; g++) begin
            check({tag, "_busy"},  g, 32'(busy[g]), 0);
            check({tag, "_done"},  g, 32'(done[g]), 0);
            check({tag, "_req"},   g, 32'(m_read_req[g]), 0);
            check({tag, "_addr"},  g, 32'(m_read_addr[g]), 0);
            check({tag, "_valid"}, g, 32'(out_valid[g]), 0);
            check({tag, "_data"},  g, 32'(out_data[g]), 0);
            check({tag, "_last"},  g, 32'(out_last[g]), 0);
        end
    endtask

    // Reference model: word k of a transfer is RAM[(base+k) mod 2^AW]; only the final one is last.
    task automatic begin_xfer(input int base, input int num, input int mode);
        word_t w;
        for (int g = 0; g < 2; g++) begin
            exp_words[g].delete();
            exp_addr[g].delete();
            for (int k = 0; k < num; k++) begin
                w.data = ram[(base + k) % NWORDS];
                w.last = (k == num - 1);
                exp_words[g].push_back(w);
                exp_addr[g].push_back((base + k) % NWORDS);
            end
            active[g]     = 1'b1;
            done_seen[g]  = 1'b0;
            xfer_num[g]   = num;
            words_seen[g] = 0;
            reads_seen[g] = 0;
            first_hs[g]   = 0;
            last_hs[g]    = 0;
        end
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = AW'(base);
        num_words = (AW + 1)'(num);
        out_ready = ready_val(mode, 0);
        start_win[0] = cyc;
        start_win[1] = cyc;
    endtask

    task automatic run_xfer(input int base, input int num, input int mode, input int ghost_at);
        int step = 1;
        begin_xfer(base, num, mode);
        while (!(done_seen[0] && done_seen[1]) && step < 4000) begin
            @(posedge clk); #1;
            if (step == ghost_at) begin
                start     = 1'b1;
                base_addr = AW'($urandom);
                num_words = (AW + 1)'($urandom_range(1, 30));
            end else begin
                start = 1'b0;
            end
            out_ready = ready_val(mode, step);
            step++;
        end
        start = 1'b0;
        for (int g = 0; g < 2; g++) begin
            if (!done_seen[g]) begin
                check("timeout", g, 0, 1);
                active[g] = 1'b0;
            end
            if (mode == 0 && num > 0)
                check("throughput", g, last_hs[g] - first_hs[g], num - 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int step;
        int base;
        int num;
        int mode;

        reset_n   = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        base_addr = '0;
        num_words = '0;
        for (int i = 0; i < NWORDS; i++) ram[i] = DW'(i + 'h10);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;

        run_xfer(4, 5, 0, -1);
        run_xfer(1022, 4, 0, -1);
        run_xfer(10, 8, 1, -1);
        run_xfer(7, 0, 0, -1);

        // Abort a long transfer once the slower reader has streamed three words.
        begin_xfer(200, 20, 0);
        step = 1;
        while (words_seen[1] < 3 && step < 200) begin
            @(posedge clk); #1;
            start = 1'b0;
            step++;
        end
        check("abort_reached_3_words", 1, 32'(words_seen[1] >= 3), 1);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("abort");
        for (int g = 0; g < 2; g++) begin
            active[g] = 1'b0;
            exp_words[g].delete();
            exp_addr[g].delete();
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        for (int g = 0; g < 2; g++) check("no_done_after_abort", g, 32'(done_seen[g]), 0);

        run_xfer(0, 2, 0, -1);
        run_xfer(100, 8, 1, 3);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < NWORDS; i++) ram[i] = DW'($urandom);
            base = $urandom_range(0, NWORDS - 1);
            num  = (t % 8 == 0) ? 0 : $urandom_range(1, 24);
            mode = $urandom_range(0, 2);
            run_xfer(base, num, mode, (num >= 4 && t % 3 == 1) ? 2 : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning RAM word and stream data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, meaning RAM address width (RAM holds 2^ADDR_WIDTH words).
REQ-003 SHALL have parameter READ_LATENCY, default 1, meaning RAM read latency in cycles; legal values are 0 (combinational read) and 1 (registered read).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset_n, input, 1 bit, synchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit, single-cycle request to begin a transfer.
REQ-007 SHALL have port base_addr, input, ADDR_WIDTH bits, first word address, sampled on an accepted start.
REQ-008 SHALL have port num_words, input, ADDR_WIDTH+1 bits, transfer length (0..2^ADDR_WIDTH), sampled on an accepted start.
REQ-009 SHALL have port busy, output, 1 bit, high from the cycle after an accepted start until the cycle done is asserted.
REQ-010 SHALL have port done, output, 1 bit, one-cycle completion pulse.
REQ-011 SHALL have port m_read_req, output, 1 bit, RAM read strobe.
REQ-012 SHALL have port m_read_addr, output, ADDR_WIDTH bits, RAM read address.
REQ-013 SHALL have port m_read_data, input, DATA_WIDTH bits, RAM read data.
REQ-014 SHALL have port out_valid, output, 1 bit, stream word valid.
REQ-015 SHALL have port out_ready, input, 1 bit, stream consumer ready.
REQ-016 SHALL have port out_data, output, DATA_WIDTH bits, stream word.
REQ-017 SHALL have port out_last, output, 1 bit, high with the final word of a transfer.

Function
REQ-018 SHALL run an FSM with states IDLE, RUN, DRAIN and DONE.
REQ-019 SHALL accept start only in IDLE; start in any other state SHALL be ignored.
REQ-020 SHALL, on an accepted start with num_words=0, go IDLE->DONE, issue no reads, emit no words, and pulse done the next cycle.
REQ-021 SHALL, on an accepted start with num_words>0, go IDLE->RUN; RUN->DRAIN after the final read issues; DRAIN->DONE once the final word handshakes; DONE->IDLE unconditionally after one cycle.
REQ-022 SHALL issue read k (k=0..num_words-1) at address (base_addr+k) mod 2^ADDR_WIDTH, so addresses wrap from 2^ADDR_WIDTH-1 to 0.
REQ-023 SHALL buffer returned words in a 2-entry FIFO and capture m_read_data READ_LATENCY cycles after the m_read_req cycle.
REQ-024 SHALL assert m_read_req only when fifo_count + reads_in_flight < 2, or when the sum equals 2 and a FIFO pop occurs in the same cycle; buffer overflow is never permitted.
REQ-025 SHALL sustain one word per cycle when out_ready is held high, for both READ_LATENCY values.
REQ-026 SHALL transfer a word when out_valid and out_ready are both high; out_data and out_last SHALL remain stable while out_valid is high and out_ready is low.
REQ-027 SHALL assert out_last only on word num_words-1.
REQ-028 SHALL produce m_read_addr equal to the last issued address when m_read_req is low; its value is don't-care to the RAM.

Reset
REQ-029 SHALL, while reset_n is low at a rising edge, enter IDLE, empty the FIFO, clear the counters, and drive busy=0, done=0, m_read_req=0, m_read_addr=0, out_valid=0, out_data=0 and out_last=0.
REQ-030 SHALL abort any in-progress transfer on reset without a done pulse, and discard read data returning after reset.

Structure
REQ-031 SHALL place the FSM state encodings and the FIFO depth constant (2) in the team's shared package/header.
REQ-032 SHALL implement the 2-entry FIFO as a sub-module named ram_rd_fifo with push, pop, count, full and empty.
REQ-033 SHALL be verified against the team's ram block configured with OUTPUT_REG matching READ_LATENCY.

Verification
REQ-034 SHALL cover: RAM[i]=i+0x10; start with base=4 and num=5, out_ready=1 -> words 0x14..0x18, one per cycle, out_last on 0x18, done one cycle after.
REQ-035 SHALL cover: base=1022, num=4, ADDR_WIDTH=10 -> read addresses 1022, 1023, 0, 1.
REQ-036 SHALL cover: num=8 with out_ready toggling 1,0,0,1 repeating -> all 8 words in order, none lost or duplicated, data stable while stalled.
REQ-037 SHALL cover: num=0 -> done pulse the cycle after start, out_valid never asserted, m_read_req never asserted.
REQ-038 SHALL cover: reset_n low during RUN after 3 words -> all outputs at reset values the next cycle, no done, and a following start (base=0, num=2) completes correctly.
REQ-039 SHALL cover: start reasserted while busy -> ignored; transfer length and addresses unchanged.
REQ-040 SHALL run all scenarios with READ_LATENCY=0 and READ_LATENCY=1.
